// File: rtl/register_file_2r1w_pkg.sv
// Shared register-file types and constants, also used by the write-register
// select mux and the decode stage.
package register_file_2r1w_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned REG_DATA_W = 32;
  localparam int unsigned REG_DEPTH  = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [REG_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/register_file_2r1w_read_port.sv
// One combinational read port: address decode, r0 force-to-zero, and the
// optional same-cycle write-to-read bypass.
module regfile_read_port
  import register_file_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] mem [(1 << ADDR_W)-1:1],
  output logic [DATA_W-1:0] rdata_c
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] stored_c;
  logic              hit_c;

  // Entry 0 has no storage; address 0 falls through to the zero default.
  always_comb begin
    stored_c = '0;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      if (raddr == ADDR_W'(i)) stored_c = mem[i];
    end
  end

  assign hit_c = BYPASS && rst_n && we &&
                 (waddr != ADDR_W'(REG_ZERO)) && (raddr == waddr);

  assign rdata_c = !rst_n ? '0 : (hit_c ? wdata : stored_c);

endmodule

// File: rtl/register_file_2r1w.sv
// 2-read / 1-write general-purpose register file with hardwired-zero r0 and
// optional write-to-read bypass.
module register_file_2r1w
  import register_file_2r1w_pkg::*;
#(
  parameter int unsigned DATA_W = REG_DATA_W,
  parameter int unsigned ADDR_W = REG_ADDR_W,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr_a,
  input  logic [ADDR_W-1:0] raddr_b,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH-1:1];
  logic [DATA_W-1:0] mem_d [DEPTH-1:1];
  logic              wr_en_c;

  assign wr_en_c = we && (waddr != ADDR_W'(REG_ZERO));

  always_comb begin
    for (int unsigned i = 1; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en_c && (waddr == ADDR_W'(i))) mem_d[i] = wdata;
    end
  end

  // Reset clears storage immediately and blocks any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_a (
    .rst_n   (rst_n),
    .raddr   (raddr_a),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .mem     (mem_q),
    .rdata_c (rdata_a)
  );

  regfile_read_port #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_port_b (
    .rst_n   (rst_n),
    .raddr   (raddr_b),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .mem     (mem_q),
    .rdata_c (rdata_b)
  );

endmodule
